pipe_stage_reg: RTL and testbench

Parametrised multi-lane pipeline register with valid/ready handshake, two-entry skid buffering, synchronous flush and a saturating stall counter. It replaces the fixed-width, global-stall pipeline registers between core stages (IF~FB, FB~ID, DP~IS, IS~RF, RF~EX, EX~WB) so that each boundary exerts local backpressure at full throughput without a combinational ready path. One instance sits at each stage boundary; lanes carry `fb_entry_t`/`micro_op_t` payloads flattened to `WIDTH` bits.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/lane_compactor.sv | 36 +++
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: per-boundary lane/width defaults and the lane-group container
// carried between core pipeline stages.
package pipe_pkg;

   localparam int DEF_LANES       = 4;
   localparam int DEF_WIDTH       = 64;
   localparam int DEF_STALL_CNT_W = 16;

   // Boundary-specific group geometry (fetch/decode/rename/issue width).
   localparam int IF_FB_LANES = 4;
   localparam int IF_FB_WIDTH = 64;
   localparam int FB_ID_LANES = 4;
   localparam int FB_ID_WIDTH = 64;
   localparam int DP_IS_LANES = 4;
   localparam int DP_IS_WIDTH = 64;
   localparam int IS_RF_LANES = 4;
   localparam int IS_RF_WIDTH = 64;
   localparam int RF_EX_LANES = 4;
   localparam int RF_EX_WIDTH = 64;
   localparam int EX_WB_LANES = 4;
   localparam int EX_WB_WIDTH = 64;

   typedef struct packed {
      logic [DEF_LANES-1:0][DEF_WIDTH-1:0] data;
      logic [DEF_LANES-1:0]                valid;
   } lane_group_t;

endpackage
`default_nettype wire

// File: rtl/lane_compactor.sv
`default_nettype none
// lane_compactor: packs valid lanes into the lowest output indices, keeping
// their relative order; unused output lanes are driven to zero.
module lane_compactor
   import pipe_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [LANES*WIDTH-1:0] data_i,
   input  logic [LANES-1:0]       valid_i,
   output logic [LANES*WIDTH-1:0] data_o,
   output logic [LANES-1:0]       valid_o
);

   always_comb begin
      int cnt;
      data_o  = '0;
      valid_o = '0;
      cnt     = 0;
      for (int i = 0; i < LANES; i++) begin
         if (valid_i[i]) begin
            // cnt is the number of valid lanes older than lane i.
            for (int j = 0; j < LANES; j++) begin
               if (j == cnt) begin
                  data_o[j*WIDTH +: WIDTH] = data_i[i*WIDTH +: WIDTH];
                  valid_o[j]               = 1'b1;
               end
            end
            cnt = cnt + 1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// pipe_stage_reg: multi-lane valid/ready pipeline register with a skid entry,
// synchronous flush and saturating stall counter. Define PIPE_STAGE_COMPACT_EN to compact lanes.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int LANES       = DEF_LANES,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [LANES*WIDTH-1:0] in_data,
   input  logic [LANES-1:0]       in_valid,
   output logic                   in_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   input  logic                   out_ready,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic [LANES*WIDTH-1:0] main_data_q, main_data_d;
   logic [LANES-1:0]       main_valid_q, main_valid_d;
   logic [LANES*WIDTH-1:0] skid_data_q, skid_data_d;
   logic [LANES-1:0]       skid_valid_q, skid_valid_d;
   logic                   in_ready_q, in_ready_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [LANES*WIDTH-1:0] grp_data;
   logic [LANES-1:0]       grp_valid;
   logic                   main_any, skid_any, acc_in, acc_out;

`ifdef PIPE_STAGE_COMPACT_EN
   lane_compactor #(
      .LANES (LANES),
      .WIDTH (WIDTH)
   ) u_compactor (
      .data_i  (in_data),
      .valid_i (in_valid),
      .data_o  (grp_data),
      .valid_o (grp_valid)
   );
`else
   assign grp_data  = in_data;
   assign grp_valid = in_valid;
`endif

   assign main_any = |main_valid_q;
   assign skid_any = |skid_valid_q;
   assign acc_in   = in_ready_q & (|in_valid);
   assign acc_out  = main_any & out_ready;

   always_comb begin
      main_data_d  = main_data_q;
      main_valid_d = main_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      stall_cnt_d  = stall_cnt_q;

      if (main_any && !out_ready && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end

      if (flush) begin
         main_data_d  = '0;
         main_valid_d = '0;
         skid_data_d  = '0;
         skid_valid_d = '0;
      end else if (!main_any || acc_out) begin
         if (skid_any) begin
            main_data_d  = skid_data_q;
            main_valid_d = skid_valid_q;
            skid_data_d  = acc_in ? grp_data  : '0;
            skid_valid_d = acc_in ? grp_valid : '0;
         end else if (acc_in) begin
            main_data_d  = grp_data;
            main_valid_d = grp_valid;
         end else begin
            main_data_d  = '0;
            main_valid_d = '0;
         end
      end else if (acc_in) begin
         skid_data_d  = grp_data;
         skid_valid_d = grp_valid;
      end
   end

   // Registered copy of !skid_valid keeps out_ready off the in_ready path.
   assign in_ready_d = ~(|skid_valid_d);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_data_q  <= '0;
         main_valid_q <= '0;
         skid_data_q  <= '0;
         skid_valid_q <= '0;
         in_ready_q   <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         main_data_q  <= main_data_d;
         main_valid_q <= main_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_data  = main_data_q;
   assign out_valid = main_valid_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg: directed tests for pipe_stage_reg (4 lanes x 8 bits, 4-bit stall counter).
module tb_pipe_stage_reg;

   localparam int LANES = 4;
   localparam int WIDTH = 8;
   localparam int SCW   = 4;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   flush = 1'b0;
   logic [LANES*WIDTH-1:0] in_data = '0;
   logic [LANES-1:0]       in_valid = '0;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] out_data;
   logic [LANES-1:0]       out_valid;
   logic                   out_ready = 1'b1;
   logic [SCW-1:0]         stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_stall = 0;

   pipe_stage_reg #(
      .LANES       (LANES),
      .WIDTH       (WIDTH),
      .STALL_CNT_W (SCW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .stall_cnt (stall_cnt)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] grp(input int g);
      logic [7:0] b;
      b = 8'(g * 16);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 4'b0000 || out_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_out: got valid=%b data=%h required valid=0000 data=0", out_valid, out_data);
      end
      tests_run++;
      if (in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got in_ready=%b stall=%0d required 1 and 0", in_ready, stall_cnt);
      end
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int g = 1; g <= 8; g++) begin
         in_data  = grp(g);
         in_valid = 4'hF;
         tick();
         tests_run++;
         if (out_data !== grp(g) || out_valid !== 4'hF || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stream_g%0d: got data=%h valid=%b rdy=%b required data=%h valid=1111 rdy=1",
                     g, out_data, out_valid, in_ready, grp(g));
         end
      end
      in_valid = '0;
      tick();
      tests_run++;
      if (out_valid !== 4'b0000 || stall_cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL stream_drain: got valid=%b stall=%0d required 0000 and 0", out_valid, stall_cnt);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      in_data = grp(1); in_valid = 4'hF;
      tick();
      in_data = grp(2); out_ready = 1'b0;
      tick();
      exp_stall = 1;
      tests_run++;
      if (out_data !== grp(1) || in_ready !== 1'b0 || stall_cnt !== SCW'(exp_stall)) begin
         tests_failed++;
         $display("FAIL bp_skid_load: got data=%h rdy=%b stall=%0d required data=%h rdy=0 stall=%0d",
                  out_data, in_ready, stall_cnt, grp(1), exp_stall);
      end
      in_data = grp(3);
      for (int k = 0; k < 2; k++) begin
         tick();
         exp_stall++;
      end
      tests_run++;
      if (out_data !== grp(1) || in_ready !== 1'b0 || stall_cnt !== SCW'(exp_stall)) begin
         tests_failed++;
         $display("FAIL bp_hold: got data=%h rdy=%b stall=%0d required data=%h rdy=0 stall=%0d",
                  out_data, in_ready, stall_cnt, grp(1), exp_stall);
      end
      out_ready = 1'b1;
      tick();
      tests_run++;
      if (out_data !== grp(2) || in_ready !== 1'b1 || stall_cnt !== SCW'(exp_stall)) begin
         tests_failed++;
         $display("FAIL bp_release: got data=%h rdy=%b stall=%0d required data=%h rdy=1 stall=%0d",
                  out_data, in_ready, stall_cnt, grp(2), exp_stall);
      end
      tick();
      tests_run++;
      if (out_data !== grp(3) || out_valid !== 4'hF) begin
         tests_failed++;
         $display("FAIL bp_next: got data=%h valid=%b required data=%h valid=1111", out_data, out_valid, grp(3));
      end
      in_valid = '0;
      tick();
      tests_run++;
      if (out_valid !== 4'b0000) begin
         tests_failed++;
         $display("FAIL bp_drain: got valid=%b required 0000", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_data = grp(4); in_valid = 4'hF;
      tick();
      in_data = grp(5);
      tick();
      exp_stall++;
      in_data = grp(6); flush = 1'b1; out_ready = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_both: got valid=%b data=%h rdy=%b required 0000 0 1", out_valid, out_data, in_ready);
      end
      flush = 1'b0; in_valid = '0;
      tick();
      tests_run++;
      if (out_valid !== 4'b0000 || stall_cnt !== SCW'(exp_stall)) begin
         tests_failed++;
         $display("FAIL flush_dropped: got valid=%b stall=%0d required 0000 stall=%0d", out_valid, stall_cnt, exp_stall);
      end
      in_data = grp(7); in_valid = 4'hF;
      tick();
      in_data = grp(8); flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = '0;
      tests_run++;
      if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_accin: got valid=%b rdy=%b required 0000 1", out_valid, in_ready);
      end
   endtask

   task automatic test_compaction();
      out_ready = 1'b1;
      in_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      in_valid = 4'b1010;
      tick();
      in_valid = '0;
`ifdef PIPE_STAGE_COMPACT_EN
      tests_run++;
      if (out_valid !== 4'b0011 || out_data[15:0] !== 16'hDDBB) begin
         tests_failed++;
         $display("FAIL compact: got valid=%b data=%h required valid=0011 low lanes=ddbb", out_valid, out_data);
      end
`else
      tests_run++;
      if (out_valid !== 4'b1010 || out_data !== 32'hDDCCBBAA) begin
         tests_failed++;
         $display("FAIL positional: got valid=%b data=%h required valid=1010 data=ddccbbaa", out_valid, out_data);
      end
`endif
      tick();
      tests_run++;
      if (out_valid !== 4'b0000) begin
         tests_failed++;
         $display("FAIL lanes_drain: got valid=%b required 0000", out_valid);
      end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      in_data = grp(1); in_valid = 4'hF;
      tick();
      in_valid = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (exp_stall < 15) exp_stall++;
         if (k == 10 - (exp_stall - 15)) begin end
         if (k == 19 - 9) begin
            tests_run++;
            if (stall_cnt !== SCW'(exp_stall)) begin
               tests_failed++;
               $display("FAIL stall_mid: got %0d required %0d", stall_cnt, exp_stall);
            end
         end
      end
      tests_run++;
      if (stall_cnt !== 4'd15 || out_data !== grp(1)) begin
         tests_failed++;
         $display("FAIL stall_sat: got stall=%0d data=%h required 15 data=%h", stall_cnt, out_data, grp(1));
      end
   endtask

   task automatic test_async_reset();
      in_data = grp(2); in_valid = 4'hF;
      tick();
      in_valid = '0;
      tests_run++;
      if (in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL pre_reset_full: got rdy=%b required 0", in_ready);
      end
      #3 reset = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
         tests_failed++;
         $display("FAIL async_reset: got valid=%b data=%h rdy=%b stall=%0d required 0000 0 1 0",
                  out_valid, out_data, in_ready, stall_cnt);
      end
      #1 reset = 1'b0;
      out_ready = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 4'b0000) begin
         tests_failed++;
         $display("FAIL post_reset: got valid=%b required 0000", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_compaction();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
